frame_sequencer: RTL

Sequences frame production and display for the vector-scope pipeline. It owns the go/halt handshake with the vector display and the fill request/done handshake with the memory builder. It selects which image source (start screen, MTM logo, game RAM, end screen) feeds the display, with screen changes applied only at frame boundaries. It also manages RAM double-buffer bank selection and a halt watchdog.

---
 rtl/frame_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frame_sequencer
// Purpose  : Frame FSM for the vector-scope pipeline. It drives the display
//            go/halt handshake and the memory-builder fill handshake, selects
//            the image source, picks the RAM bank and runs a halt watchdog.
//            Define FRAME_PREFILL_EN to fill the back bank while drawing.
// Revision : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int HALT_TIMEOUT = 4_000_000,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 startgame,
    input  logic                 mtm_show,
    input  logic                 show_death,
    input  logic                 base1_nuked,
    input  logic                 base2_nuked,
    input  logic                 base3_nuked,
    input  logic                 fill_done,
    input  logic                 halt,
    output logic                 fill_req,
    output logic                 fill_bank,
    output logic                 bank,
    output logic                 go,
    output logic [1:0]           src_sel,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 timeout_err
);

    localparam int              c_wd_w    = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(HALT_TIMEOUT - 1);

    localparam logic [1:0] c_src_start = 2'd0;
    localparam logic [1:0] c_src_mtm   = 2'd1;
    localparam logic [1:0] c_src_game  = 2'd2;
    localparam logic [1:0] c_src_end   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_DRAW   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_START = 2'd0,
        MODE_GAME  = 2'd1,
        MODE_END   = 2'd2
    } mode_t;

    state_t               r_state;
    state_t               w_state_nxt;
    mode_t                r_mode;
    mode_t                w_mode_nxt;
    logic [1:0]           r_src_sel;
    logic [1:0]           w_src_nxt;
    logic                 r_sg_prev;
    logic                 r_sg_pend;
    logic                 w_sg_rise;
    logic                 w_sg_edge;
    logic [c_wd_w-1:0]    r_wd;
    logic                 w_wd_fire;
    logic                 w_frame_end;
    logic                 w_eval;
    logic                 w_next_game;
    logic                 w_prefill_rdy;
    logic                 w_fill_req_nxt;
    logic                 r_go;
    logic                 r_fill_req;
    logic                 r_timeout_err;
    logic [CNT_WIDTH-1:0] r_frame_cnt;

    assign w_sg_rise   = startgame & ~r_sg_prev;
    assign w_sg_edge   = r_sg_pend | w_sg_rise;
    assign w_wd_fire   = (r_state == ST_DRAW) && (r_wd == c_wd_last);
    assign w_frame_end = (r_state == ST_DRAW) && (halt || w_wd_fire);
    assign w_eval      = (r_state == ST_IDLE) || w_frame_end;
    assign w_next_game = (w_src_nxt == c_src_game);

    // One mode step per evaluation; a single startgame edge cannot chain END->START->GAME.
    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            MODE_START: if (w_sg_edge) w_mode_nxt = MODE_GAME;
            MODE_GAME:  if (show_death || (base1_nuked && base2_nuked && base3_nuked))
                            w_mode_nxt = MODE_END;
            MODE_END:   if (w_sg_edge) w_mode_nxt = MODE_START;
            default:    w_mode_nxt = MODE_START;
        endcase

        if (mtm_show) begin
            w_src_nxt = c_src_mtm;
        end else begin
            case (w_mode_nxt)
                MODE_GAME: w_src_nxt = c_src_game;
                MODE_END:  w_src_nxt = c_src_end;
                default:   w_src_nxt = c_src_start;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = w_next_game ? ST_FILL : ST_LAUNCH;
            ST_FILL:   if (fill_done) w_state_nxt = ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_DRAW;
            ST_DRAW:   if (w_frame_end)
                           w_state_nxt = (w_next_game && !w_prefill_rdy) ? ST_FILL : ST_LAUNCH;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef FRAME_PREFILL_EN
    logic r_prefill_ok;
    logic r_bank;
    logic r_fill_bank;
    logic w_prefill_set;

    // The prefill window is a DRAW of a game frame; a done coinciding with halt still counts.
    assign w_prefill_set  = (r_state == ST_DRAW) && (r_src_sel == c_src_game) && fill_done;
    assign w_prefill_rdy  = r_prefill_ok || w_prefill_set;
    assign w_fill_req_nxt = (w_state_nxt == ST_FILL) ||
                            ((w_state_nxt == ST_DRAW) && (r_src_sel == c_src_game) && !w_prefill_rdy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prefill_ok <= 1'b0;
            r_bank       <= 1'b0;
            r_fill_bank  <= 1'b1;
        end else begin
            if (w_frame_end) begin
                r_prefill_ok <= 1'b0;
            end else if (w_prefill_set) begin
                r_prefill_ok <= 1'b1;
            end
            // Every game launch shows a freshly written bank, so swap as go rises.
            if ((r_state == ST_LAUNCH) && (r_src_sel == c_src_game)) begin
                r_bank      <= ~r_bank;
                r_fill_bank <= r_bank;
            end
        end
    end

    assign bank      = r_bank;
    assign fill_bank = r_fill_bank;
`else
    assign w_prefill_rdy  = 1'b0;
    assign w_fill_req_nxt = (w_state_nxt == ST_FILL);
    assign bank           = 1'b0;
    assign fill_bank      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_START;
            r_src_sel     <= c_src_start;
            r_sg_prev     <= 1'b0;
            r_sg_pend     <= 1'b0;
            r_wd          <= '0;
            r_go          <= 1'b0;
            r_fill_req    <= 1'b0;
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sg_prev <= startgame;
            if (w_eval) begin
                r_mode    <= w_mode_nxt;
                r_src_sel <= w_src_nxt;
                r_sg_pend <= 1'b0;
            end else if (w_sg_rise) begin
                r_sg_pend <= 1'b1;
            end
            if (r_state == ST_DRAW) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
            r_go <= (r_state == ST_LAUNCH);
            if (r_state == ST_LAUNCH) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            r_fill_req <= w_fill_req_nxt;
            if (w_wd_fire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign go          = r_go;
    assign fill_req    = r_fill_req;
    assign src_sel     = r_src_sel;
    assign frame_cnt   = r_frame_cnt;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
